// File: rtl/tile_read_arbiter.sv
// tile_read_arbiter: round-robin arbiter sharing one tile-memory read port among row routers.
module tile_read_arbiter #(
    parameter int ROW_COUNT  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic                            i_reg_clear,
    input  logic [ROW_COUNT-1:0]            i_req,
    input  logic [ROW_COUNT*ADDR_WIDTH-1:0] i_req_addr,
    output logic [ROW_COUNT-1:0]            o_gnt,
    output logic                            o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           o_mem_addr,
    input  logic [DATA_WIDTH-1:0]           i_mem_data,
    output logic [DATA_WIDTH-1:0]           o_rd_data,
    output logic [ROW_COUNT-1:0]            o_rd_valid,
    output logic                            o_busy,
    output logic [15:0]                     o_txn_count
);
    localparam int PW = $clog2(ROW_COUNT);
    localparam logic [1:0] IDLE = 2'd0, ISSUE_WAIT = 2'd1, CAPTURE = 2'd2;
    localparam logic [ROW_COUNT-1:0] ONE = {{(ROW_COUNT-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [PW-1:0] rr_ptr, winner, sel;

    // Descending scan so the final assignment is the first requester at or after rr_ptr.
    always_comb begin
        sel = '0;
        for (int i = ROW_COUNT - 1; i >= 0; i--)
            if (i_req[(int'(rr_ptr) + i) % ROW_COUNT]) sel = PW'((int'(rr_ptr) + i) % ROW_COUNT);
    end

    assign o_busy = state != IDLE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_reg_clear) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            winner      <= '0;
            o_gnt       <= '0;
            o_rd_valid  <= '0;
            o_mem_rd_en <= 1'b0;
            o_mem_addr  <= '0;
            o_rd_data   <= '0;
            o_txn_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    o_rd_valid <= '0;
                    if (i_en && |i_req) begin
                        winner      <= sel;
                        o_gnt       <= ONE << sel;
                        o_mem_addr  <= i_req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
                        o_mem_rd_en <= 1'b1;
                        state       <= ISSUE_WAIT;
                    end
                end
                ISSUE_WAIT: begin
                    o_gnt       <= '0;
                    o_mem_rd_en <= 1'b0;
                    state       <= CAPTURE;
                end
                CAPTURE: begin
                    o_rd_data   <= i_mem_data;
                    o_rd_valid  <= ONE << winner;
                    rr_ptr      <= (winner == PW'(ROW_COUNT - 1)) ? '0 : winner + 1'b1;
                    o_txn_count <= (o_txn_count == 16'hFFFF) ? o_txn_count : o_txn_count + 16'd1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
